// File: rtl/fir_detect_qualifier.sv
// rtl/fir_detect_qualifier.sv - qualifies the FIR threshold bit into a debounced detect with holdoff and event count
module fir_detect_qualifier #(
    parameter int ON_CNT  = 4,
    parameter int OFF_CNT = 3,
    parameter int HOLDOFF = 8,
    parameter int EVT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             y_in,
    input  logic             clr_cnt,
    output logic             detect,
    output logic             rise_pulse,
    output logic [EVT_W-1:0] event_cnt,
    output logic             sat
);

    generate
        if (ON_CNT < 2 || ON_CNT > 255 || OFF_CNT < 2 || OFF_CNT > 255 ||
            HOLDOFF < 0 || HOLDOFF > 255 || EVT_W < 1) begin : g_bad_params
            $error("fir_detect_qualifier: illegal parameter value");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMING,
        S_ACTIVE,
        S_RELEASING,
        S_HOLDOFF
    } state_t;

    localparam logic [7:0]       ON_LAST   = 8'(ON_CNT - 1);
    localparam logic [7:0]       OFF_LAST  = 8'(OFF_CNT - 1);
    localparam logic [7:0]       HOLD_LAST = 8'(HOLDOFF - 1);
    localparam logic [EVT_W-1:0] CNT_MAX   = {EVT_W{1'b1}};

    state_t           state_q, state_d;
    logic [7:0]       run_q, run_d;
    logic [7:0]       timer_q, timer_d;
    logic             detect_q, detect_d;
    logic             rise_q, rise_d;
    logic [EVT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        timer_d = timer_q;
        rise_d  = 1'b0;
        if (!en) begin
            state_d = S_IDLE;
            run_d   = 8'd0;
            timer_d = 8'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (y_in) begin
                        state_d = S_ARMING;
                        run_d   = 8'd1;
                    end
                end
                S_ARMING: begin
                    if (!y_in) begin
                        state_d = S_IDLE;
                        run_d   = 8'd0;
                    end else if (run_q == ON_LAST) begin
                        state_d = S_ACTIVE;
                        run_d   = 8'd0;
                        rise_d  = 1'b1;
                    end else begin
                        run_d = run_q + 8'd1;
                    end
                end
                S_ACTIVE: begin
                    if (!y_in) begin
                        state_d = S_RELEASING;
                        run_d   = 8'd1;
                    end
                end
                S_RELEASING: begin
                    if (y_in) begin
                        // a glitch back to high keeps the same detection alive
                        state_d = S_ACTIVE;
                        run_d   = 8'd0;
                    end else if (run_q == OFF_LAST) begin
                        state_d = (HOLDOFF == 0) ? S_IDLE : S_HOLDOFF;
                        run_d   = 8'd0;
                        timer_d = 8'd0;
                    end else begin
                        run_d = run_q + 8'd1;
                    end
                end
                S_HOLDOFF: begin
                    if (timer_q == HOLD_LAST) begin
                        state_d = S_IDLE;
                        timer_d = 8'd0;
                    end else begin
                        timer_d = timer_q + 8'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    run_d   = 8'd0;
                    timer_d = 8'd0;
                end
            endcase
        end
        detect_d = (state_d == S_ACTIVE) || (state_d == S_RELEASING);
    end

    // clear wins over the increment, except that a coincident new event still counts as one
    always_comb begin
        cnt_d = cnt_q;
        sat_d = sat_q;
        if (clr_cnt) begin
            cnt_d = rise_d ? EVT_W'(1) : '0;
            sat_d = 1'b0;
        end else if (rise_d && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + EVT_W'(1);
            sat_d = (cnt_d == CNT_MAX);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            run_q    <= 8'd0;
            timer_q  <= 8'd0;
            detect_q <= 1'b0;
            rise_q   <= 1'b0;
            cnt_q    <= '0;
            sat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            run_q    <= run_d;
            timer_q  <= timer_d;
            detect_q <= detect_d;
            rise_q   <= rise_d;
            cnt_q    <= cnt_d;
            sat_q    <= sat_d;
        end
    end

    assign detect     = detect_q;
    assign rise_pulse = rise_q;
    assign event_cnt  = cnt_q;
    assign sat        = sat_q;

endmodule
